// File: rtl/rom_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rom_port_arbiter
// Description : Shares one single-port, combinational-read program ROM between
//               the instruction-fetch port (IF) and a data-load port (D).
//               Round-robin arbitration, byte-to-word address conversion,
//               range/alignment checking and one registered response slot
//               per port with valid/ready backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module rom_port_arbiter #(
  parameter int DEPTH = 1024,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  // Instruction-fetch port
  input  logic        if_req_valid,
  input  logic [31:0] if_req_addr,
  output logic        if_req_ready,
  output logic        if_rsp_valid,
  input  logic        if_rsp_ready,
  output logic [31:0] if_rsp_data,
  output logic        if_rsp_err,
  // Data-load port
  input  logic        d_req_valid,
  input  logic [31:0] d_req_addr,
  output logic        d_req_ready,
  output logic        d_rsp_valid,
  input  logic        d_rsp_ready,
  output logic [31:0] d_rsp_data,
  output logic        d_rsp_err,
  // ROM interface
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_data
);

  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } port_e;

  slot_e       if_slot_q, if_slot_d;
  slot_e       d_slot_q,  d_slot_d;
  port_e       last_grant_q, last_grant_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] d_data_q,  d_data_d;
  logic        if_err_q,  if_err_d;
  logic        d_err_q,   d_err_d;

  logic        if_drain, d_drain;
  logic        if_elig,  d_elig;
  logic        gnt_if,   gnt_d;
  logic [31:0] gnt_addr;
  logic        gnt_err;
  logic [31:0] gnt_word;

  // Eligibility and round-robin grant: a port may be granted when its slot is
  // free or is being drained this very cycle; ties go to the port not served last.
  always_comb begin
    if_drain = (if_slot_q == SLOT_FULL) && if_rsp_ready;
    d_drain  = (d_slot_q  == SLOT_FULL) && d_rsp_ready;
    if_elig  = if_req_valid && ((if_slot_q == SLOT_EMPTY) || if_drain);
    d_elig   = d_req_valid  && ((d_slot_q  == SLOT_EMPTY) || d_drain);
    gnt_if   = 1'b0;
    gnt_d    = 1'b0;
    if (if_elig && d_elig) begin
      if (last_grant_q == GNT_D) gnt_if = 1'b1;
      else                       gnt_d  = 1'b1;
    end else if (if_elig) begin
      gnt_if = 1'b1;
    end else if (d_elig) begin
      gnt_d = 1'b1;
    end
  end

  // Address mux, word-index conversion and range/alignment check for the winner.
  always_comb begin
    gnt_addr = gnt_d ? d_req_addr : if_req_addr;
    gnt_err  = (gnt_addr[1:0] != 2'b00) || ({2'b00, gnt_addr[31:2]} >= DEPTH_U);
    gnt_word = gnt_err ? 32'h0 : mem_data;
    mem_addr = 32'h0;
    if (gnt_if || gnt_d) begin
      mem_addr = {{(32 - IDX_W){1'b0}}, gnt_addr[IDX_W+1:2]};
    end
  end

  // Next state of both response slots and the round-robin pointer.
  always_comb begin
    if_slot_d    = if_slot_q;
    if_data_d    = if_data_q;
    if_err_d     = if_err_q;
    d_slot_d     = d_slot_q;
    d_data_d     = d_data_q;
    d_err_d      = d_err_q;
    last_grant_d = last_grant_q;

    if (gnt_if) begin
      if_slot_d    = SLOT_FULL;
      if_data_d    = gnt_word;
      if_err_d     = gnt_err;
      last_grant_d = GNT_IF;
    end else if (if_drain) begin
      if_slot_d = SLOT_EMPTY;
    end

    if (gnt_d) begin
      d_slot_d     = SLOT_FULL;
      d_data_d     = gnt_word;
      d_err_d      = gnt_err;
      last_grant_d = GNT_D;
    end else if (d_drain) begin
      d_slot_d = SLOT_EMPTY;
    end
  end

  // State registers; reset discards any held responses and favours IF first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_slot_q    <= SLOT_EMPTY;
      if_data_q    <= 32'h0;
      if_err_q     <= 1'b0;
      d_slot_q     <= SLOT_EMPTY;
      d_data_q     <= 32'h0;
      d_err_q      <= 1'b0;
      last_grant_q <= GNT_D;
    end else begin
      if_slot_q    <= if_slot_d;
      if_data_q    <= if_data_d;
      if_err_q     <= if_err_d;
      d_slot_q     <= d_slot_d;
      d_data_q     <= d_data_d;
      d_err_q      <= d_err_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Handshake and response outputs.
  always_comb begin
    if_req_ready = gnt_if;
    d_req_ready  = gnt_d;
    if_rsp_valid = (if_slot_q == SLOT_FULL);
    d_rsp_valid  = (d_slot_q  == SLOT_FULL);
    if_rsp_data  = if_data_q;
    if_rsp_err   = if_err_q;
    d_rsp_data   = d_data_q;
    d_rsp_err    = d_err_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_rom_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rom_port_arbiter
// Description : Self-checking bench for rom_port_arbiter: directed scenarios
//               plus a randomized run against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_port_arbiter;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req_valid = 1'b0;
  logic [31:0] if_req_addr = 32'h0;
  logic        if_req_ready;
  logic        if_rsp_valid;
  logic        if_rsp_ready = 1'b0;
  logic [31:0] if_rsp_data;
  logic        if_rsp_err;
  logic        d_req_valid = 1'b0;
  logic [31:0] d_req_addr = 32'h0;
  logic        d_req_ready;
  logic        d_rsp_valid;
  logic        d_rsp_ready = 1'b0;
  logic [31:0] d_rsp_data;
  logic        d_rsp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;

  logic [31:0] rom [0:DEPTH-1];
  int ntests = 0;
  int nfail  = 0;

  rom_port_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_rsp_valid(if_rsp_valid), .if_rsp_ready(if_rsp_ready),
    .if_rsp_data(if_rsp_data), .if_rsp_err(if_rsp_err),
    .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_ready(d_req_ready),
    .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready),
    .d_rsp_data(d_rsp_data), .d_rsp_err(d_rsp_err),
    .mem_addr(mem_addr), .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  // Combinational ROM model.
  assign mem_data = rom[mem_addr[9:0]];

  // Expected {err, data} for a byte address.
  function automatic logic [32:0] exp_rsp(input logic [31:0] a);
    if (a[1:0] != 2'b00 || a[31:2] >= 30'(DEPTH)) return {1'b1, 32'h0};
    return {1'b0, rom[a[11:2]]};
  endfunction

  function automatic logic [31:0] rnd_aligned();
    logic [31:0] w;
    w = 32'($urandom_range(0, DEPTH - 1));
    return w << 2;
  endfunction

  function automatic logic [31:0] rnd_addr();
    int unsigned r;
    logic [31:0] w;
    r = $urandom_range(0, 15);
    if (r == 0) begin
      w = $urandom;
      return w | 32'h0000_1000;
    end
    if (r == 1) begin
      w = 32'($urandom_range(1, 3));
      return rnd_aligned() | w;
    end
    return rnd_aligned();
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req_valid = 1'b0; if_req_addr = 32'h0; if_rsp_ready = 1'b0;
    d_req_valid  = 1'b0; d_req_addr  = 32'h0; d_rsp_ready  = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #2;
    ntests++; if (if_rsp_valid !== 1'b0) begin nfail++; $display("FAIL reset_if_rsp_valid got=%b exp=0", if_rsp_valid); end
    ntests++; if (d_rsp_valid !== 1'b0) begin nfail++; $display("FAIL reset_d_rsp_valid got=%b exp=0", d_rsp_valid); end
    ntests++; if ({if_rsp_data, d_rsp_data} !== 64'h0) begin nfail++; $display("FAIL reset_data got=%h/%h exp=0", if_rsp_data, d_rsp_data); end
    ntests++; if ({if_rsp_err, d_rsp_err} !== 2'b00) begin nfail++; $display("FAIL reset_err got=%b%b exp=00", if_rsp_err, d_rsp_err); end
    ntests++; if ({if_req_ready, d_req_ready} !== 2'b00) begin nfail++; $display("FAIL reset_req_ready got=%b%b exp=00", if_req_ready, d_req_ready); end
    ntests++; if (mem_addr !== 32'h0) begin nfail++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
  endtask

  task automatic test_if_stream();
    apply_reset();
    if_rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if_req_valid = (k < 3);
      if_req_addr  = 32'(k * 4);
      @(negedge clk);
      if (k > 0) begin
        ntests++; if (if_rsp_valid !== 1'b1 || if_rsp_data !== rom[k-1] || if_rsp_err !== 1'b0) begin
          nfail++; $display("FAIL if_stream_rsp%0d got v=%b d=%h e=%b exp v=1 d=%h e=0", k-1, if_rsp_valid, if_rsp_data, if_rsp_err, rom[k-1]);
        end
      end
      if (k < 3) begin
        ntests++; if (if_req_ready !== 1'b1 || mem_addr !== 32'(k)) begin
          nfail++; $display("FAIL if_stream_grant%0d got rdy=%b maddr=%h exp rdy=1 maddr=%h", k, if_req_ready, mem_addr, k);
        end
      end
      cyc();
    end
    @(negedge clk);
    ntests++; if (if_rsp_valid !== 1'b0) begin nfail++; $display("FAIL if_stream_drained got=%b exp=0", if_rsp_valid); end
    cyc();
  endtask

  task automatic test_round_robin();
    logic [31:0] a_if, a_d, exp_last;
    apply_reset();
    if_rsp_ready = 1'b1; d_rsp_ready = 1'b1;
    a_if = rnd_aligned(); a_d = rnd_aligned(); exp_last = 32'h0;
    for (int k = 0; k < 8; k++) begin
      if_req_valid = 1'b1; if_req_addr = a_if;
      d_req_valid  = 1'b1; d_req_addr  = a_d;
      @(negedge clk);
      ntests++; if (if_req_ready !== (k % 2 == 0) || d_req_ready !== (k % 2 == 1)) begin
        nfail++; $display("FAIL rr_grant%0d got if=%b d=%b exp if=%b", k, if_req_ready, d_req_ready, (k % 2 == 0));
      end
      if (k > 0 && (k % 2 == 1)) begin
        ntests++; if (if_rsp_valid !== 1'b1 || if_rsp_data !== exp_last) begin
          nfail++; $display("FAIL rr_if_rsp%0d got v=%b d=%h exp v=1 d=%h", k, if_rsp_valid, if_rsp_data, exp_last);
        end
      end
      if (k > 0 && (k % 2 == 0)) begin
        ntests++; if (d_rsp_valid !== 1'b1 || d_rsp_data !== exp_last) begin
          nfail++; $display("FAIL rr_d_rsp%0d got v=%b d=%h exp v=1 d=%h", k, d_rsp_valid, d_rsp_data, exp_last);
        end
      end
      if (k % 2 == 0) begin exp_last = rom[a_if[11:2]]; a_if = rnd_aligned(); end
      else            begin exp_last = rom[a_d[11:2]];  a_d  = rnd_aligned(); end
      cyc();
    end
    idle_inputs();
  endtask

  task automatic test_errors();
    logic [31:0] addrs [5];
    logic        errs  [5];
    logic [31:0] a;
    logic [31:0] exp_d;
    addrs = '{32'h0000_0006, 32'h0000_1000, 32'h0000_0003, 32'h0000_0FFC, 32'hFFFF_FFF0};
    errs  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    apply_reset();
    d_rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a = addrs[i];
      d_req_valid = 1'b1; d_req_addr = a;
      @(negedge clk);
      ntests++; if (d_req_ready !== 1'b1 || mem_addr !== {22'h0, a[11:2]}) begin
        nfail++; $display("FAIL err_grant a=%h got rdy=%b maddr=%h exp rdy=1 maddr=%h", a, d_req_ready, mem_addr, {22'h0, a[11:2]});
      end
      cyc();
      d_req_valid = 1'b0;
      exp_d = errs[i] ? 32'h0 : rom[a[11:2]];
      @(negedge clk);
      ntests++; if (d_rsp_valid !== 1'b1 || d_rsp_err !== errs[i] || d_rsp_data !== exp_d) begin
        nfail++; $display("FAIL err_rsp a=%h got v=%b e=%b d=%h exp v=1 e=%b d=%h", a, d_rsp_valid, d_rsp_err, d_rsp_data, errs[i], exp_d);
      end
      cyc();
    end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    logic [31:0] a0, a1, b, exp_if, exp_d;
    apply_reset();
    a0 = rnd_aligned(); a1 = rnd_aligned(); b = rnd_aligned();
    if_req_valid = 1'b1; if_req_addr = a0; if_rsp_ready = 1'b0;
    d_req_valid  = 1'b1; d_req_addr  = b;  d_rsp_ready  = 1'b1;
    @(negedge clk);
    ntests++; if (if_req_ready !== 1'b1 || d_req_ready !== 1'b0) begin
      nfail++; $display("FAIL bp_first got if=%b d=%b exp if=1 d=0", if_req_ready, d_req_ready);
    end
    exp_if = rom[a0[11:2]]; exp_d = 32'h0;
    cyc();
    if_req_addr = a1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      ntests++; if (if_req_ready !== 1'b0 || d_req_ready !== 1'b1) begin
        nfail++; $display("FAIL bp_hold_grant%0d got if=%b d=%b exp if=0 d=1", k, if_req_ready, d_req_ready);
      end
      ntests++; if (if_rsp_valid !== 1'b1 || if_rsp_data !== exp_if) begin
        nfail++; $display("FAIL bp_hold_data%0d got v=%b d=%h exp v=1 d=%h", k, if_rsp_valid, if_rsp_data, exp_if);
      end
      if (k >= 2) begin
        ntests++; if (d_rsp_valid !== 1'b1 || d_rsp_data !== exp_d) begin
          nfail++; $display("FAIL bp_d_rsp%0d got v=%b d=%h exp v=1 d=%h", k, d_rsp_valid, d_rsp_data, exp_d);
        end
      end
      exp_d = rom[b[11:2]];
      b = rnd_aligned();
      cyc();
      d_req_addr = b;
    end
    if_rsp_ready = 1'b1;
    @(negedge clk);
    ntests++; if (if_req_ready !== 1'b1 || d_req_ready !== 1'b0) begin
      nfail++; $display("FAIL bp_release_grant got if=%b d=%b exp if=1 d=0", if_req_ready, d_req_ready);
    end
    ntests++; if (if_rsp_data !== exp_if || d_rsp_data !== exp_d) begin
      nfail++; $display("FAIL bp_release_data got if=%h d=%h exp if=%h d=%h", if_rsp_data, d_rsp_data, exp_if, exp_d);
    end
    exp_if = rom[a1[11:2]];
    cyc();
    if_req_valid = 1'b0; d_req_valid = 1'b0;
    @(negedge clk);
    ntests++; if (if_rsp_valid !== 1'b1 || if_rsp_data !== exp_if || d_rsp_valid !== 1'b0) begin
      nfail++; $display("FAIL bp_after got ifv=%b ifd=%h dv=%b exp ifv=1 ifd=%h dv=0", if_rsp_valid, if_rsp_data, d_rsp_valid, exp_if);
    end
    cyc();
    idle_inputs();
  endtask

  task automatic test_async_reset();
    apply_reset();
    if_req_valid = 1'b1; if_req_addr = rnd_aligned();
    d_req_valid  = 1'b1; d_req_addr  = rnd_aligned();
    cyc();
    cyc();
    if_req_valid = 1'b0; d_req_valid = 1'b0;
    @(negedge clk);
    ntests++; if (if_rsp_valid !== 1'b1 || d_rsp_valid !== 1'b1) begin
      nfail++; $display("FAIL areset_filled got if=%b d=%b exp 1/1", if_rsp_valid, d_rsp_valid);
    end
    cyc();
    #2;
    rst_n = 1'b0;
    #1;
    ntests++; if (if_rsp_valid !== 1'b0 || d_rsp_valid !== 1'b0 || if_rsp_data !== 32'h0 || d_rsp_data !== 32'h0) begin
      nfail++; $display("FAIL areset_immediate got v=%b%b d=%h/%h exp v=00 d=0", if_rsp_valid, d_rsp_valid, if_rsp_data, d_rsp_data);
    end
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    ntests++; if (if_rsp_valid !== 1'b0 || d_rsp_valid !== 1'b0) begin
      nfail++; $display("FAIL areset_after got if=%b d=%b exp 0/0", if_rsp_valid, d_rsp_valid);
    end
    cyc();
  endtask

  task automatic test_random();
    logic [32:0] q_if [$];
    logic [32:0] q_d  [$];
    logic [32:0] got, exp;
    logic        last_d, e_if, e_d, g_if, g_d, acc_if, acc_d;
    logic [31:0] exp_maddr;
    apply_reset();
    last_d = 1'b1; acc_if = 1'b0; acc_d = 1'b0;
    for (int n = 0; n < 10000; n++) begin
      if (!if_req_valid || acc_if) begin
        if_req_valid = ($urandom_range(0, 3) != 0);
        if_req_addr  = rnd_addr();
      end
      if (!d_req_valid || acc_d) begin
        d_req_valid = ($urandom_range(0, 2) != 0);
        d_req_addr  = rnd_addr();
      end
      if_rsp_ready = ($urandom_range(0, 9) < 7);
      d_rsp_ready  = ($urandom_range(0, 9) < 6);
      @(negedge clk);
      e_if = if_req_valid && (!if_rsp_valid || if_rsp_ready);
      e_d  = d_req_valid  && (!d_rsp_valid  || d_rsp_ready);
      g_if = e_if && (!e_d || last_d);
      g_d  = e_d  && (!e_if || !last_d);
      if (g_if) last_d = 1'b0;
      if (g_d)  last_d = 1'b1;
      exp_maddr = g_if ? {22'h0, if_req_addr[11:2]} : (g_d ? {22'h0, d_req_addr[11:2]} : 32'h0);
      ntests++; if (if_req_ready !== g_if || d_req_ready !== g_d) begin
        nfail++; $display("FAIL rnd_grant n=%0d got if=%b d=%b exp if=%b d=%b", n, if_req_ready, d_req_ready, g_if, g_d);
      end
      ntests++; if (mem_addr !== exp_maddr) begin
        nfail++; $display("FAIL rnd_mem_addr n=%0d got=%h exp=%h", n, mem_addr, exp_maddr);
      end
      ntests++; if (if_rsp_valid !== (q_if.size() != 0) || d_rsp_valid !== (q_d.size() != 0)) begin
        nfail++; $display("FAIL rnd_rsp_valid n=%0d got if=%b d=%b exp if=%b d=%b", n, if_rsp_valid, d_rsp_valid, (q_if.size() != 0), (q_d.size() != 0));
      end
      if (if_rsp_valid && if_rsp_ready) begin
        got = {if_rsp_err, if_rsp_data};
        exp = (q_if.size() != 0) ? q_if.pop_front() : 33'h1_DEAD_BEEF;
        ntests++; if (got !== exp) begin
          nfail++; $display("FAIL rnd_if_rsp n=%0d got=%h exp=%h", n, got, exp);
        end
      end
      if (d_rsp_valid && d_rsp_ready) begin
        got = {d_rsp_err, d_rsp_data};
        exp = (q_d.size() != 0) ? q_d.pop_front() : 33'h1_DEAD_BEEF;
        ntests++; if (got !== exp) begin
          nfail++; $display("FAIL rnd_d_rsp n=%0d got=%h exp=%h", n, got, exp);
        end
      end
      acc_if = if_req_valid && if_req_ready;
      acc_d  = d_req_valid  && d_req_ready;
      if (acc_if) q_if.push_back(exp_rsp(if_req_addr));
      if (acc_d)  q_d.push_back(exp_rsp(d_req_addr));
      cyc();
    end
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) rom[i] = $urandom;
    test_reset();
    test_if_stream();
    test_round_robin();
    test_errors();
    test_backpressure();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
`default_nettype wire
